uart_frame_packer: RTL and testbench
====================================

# uart_frame_packer

Parametrised byte serializer between the scan/ADC capture path and the UART transmitter. It accepts one multi-byte sample per handshake and emits it MSB-first as UART bytes, optionally preceded by a run of 0x00 header bytes that mark frame start. Data bytes equal to 0x00 are substituted so the header stays unique. Byte pacing is driven by the transmitter's `tx_empty` feedback rather than a fixed cycle count.

## Interface
- `SAMPLE_BYTES`, 3: bytes per sample, legal range 1..8.
- `HEADER_BYTES`, 2: 0x00 bytes sent before a header sample, legal range 0..7.
- `ZERO_SUB`, 8'h01: replacement value for any data byte equal to 0x00.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `sample_valid`, in, 1: sample offered.
- `sample_data`, in, SAMPLE_BYTES*8: sample, byte SAMPLE_BYTES-1 (MSB) sent first.
- `sample_head`, in, 1: sample is the first of a scan frame; prepend header.
- `sample_ready`, out, 1: block can accept a sample.
- `ld_tx_data`, out, 1: one-cycle load strobe to the UART.
- `tx_data`, out, 8: byte to transmit.
- `tx_enable`, out, 1: UART transmit enable.
- `tx_empty`, in, 1: UART shift register empty.
- `send_done`, out, 1: one-cycle pulse, sample fully sent.
- `busy`, out, 1: a frame is in progress.

## Operation
- States: IDLE, LOAD, LD, WAIT, NEXT, DONE.
- IDLE: `sample_ready`=1. On `sample_valid`&&`sample_ready`, capture `sample_data` and `sample_head` into buffers and clear `byte_idx`. Set `total` = SAMPLE_BYTES + (head ? HEADER_BYTES : 0). Go to LOAD.
- LOAD: register `tx_data`.
  - While `byte_idx` < header count: `tx_data`=0x00.
  - Otherwise: the next data byte MSB-first; if it equals 0x00, send ZERO_SUB. Go to LD.
- LD: `ld_tx_data`=1 for exactly one cycle. Go to WAIT.
- WAIT: hold. Exit only when `tx_empty`=1 and at least one cycle has been spent in WAIT. The first-cycle value of `tx_empty` is ignored because the UART updates it one cycle after the load. Go to NEXT.
- NEXT: if `byte_idx`==`total`-1, go to DONE; else increment `byte_idx` and go to LOAD.
- DONE: `send_done`=1 for one cycle. Go to IDLE.
- Level outputs:
  - `tx_enable`=1 and `busy`=1 in every state except IDLE.
  - `sample_ready`=(state==IDLE)&&!reset.
- `tx_data` holds its value from LOAD through NEXT. It is 0x00 in IDLE and DONE.
- When HEADER_BYTES=0, `sample_head` has no effect.
- `byte_idx` width is $clog2(SAMPLE_BYTES+HEADER_BYTES+1). No wrap is possible within legal parameter ranges.
- Parameters outside their legal range cause an elaboration-time `$error`.

## Timing
- Reset: state IDLE; `ld_tx_data`, `tx_data`, `tx_enable`, `send_done`, `busy` all 0; `sample_ready`=0 while reset is high.
- Reset asserted mid-frame aborts the frame on the next edge. No `send_done` is produced and the buffered sample is discarded.
- Accept at cycle t. LOAD at t+1, where `tx_data` becomes valid at t+2. LD at t+2, with `ld_tx_data`=1 during t+2.
- Per byte: LOAD + LD + NEXT + WAIT. WAIT lasts ≥1 cycle and ends when `tx_empty` rises.
- `send_done` is asserted the cycle after the NEXT that follows the last byte's WAIT. `sample_ready` returns 1 the cycle after DONE.
- `sample_valid` is ignored while `sample_ready`=0. The source must hold data until accepted.
- `tx_empty` stuck low keeps the block in WAIT indefinitely, with no re-load and no timeout.

## Structure
- Shared package `uart_pack_pkg` contains:
  - the state enum;
  - the default ZERO_SUB constant;
  - the HEADER_BYTE=8'h00 constant, also used by the host-side decoder model.
- One natural combinational sub-module, `uart_byte_sel`. It takes the buffered sample, `byte_idx` and the header count, and returns the outgoing byte with zero substitution applied. The FSM, counters and buffers stay in the top module.

## Test plan
- Defaults, `sample_head`=0, data 0x120034 → `tx_data` bytes 0x12, 0x01, 0x34. Exactly 3 `ld_tx_data` pulses and 1 `send_done`.
- Defaults, `sample_head`=1, data 0xAABBCC → bytes 0x00, 0x00, 0xAA, 0xBB, 0xCC. 5 loads, then `send_done`.
- `sample_valid` held high with 3 back-to-back samples, UART model with 10-cycle bytes → `sample_ready` low during each frame. Each sample is sent once, in order, with no loss or duplication.
- `tx_empty` held low for 50 cycles after the first load → the block stays in WAIT with `tx_data` stable and no extra `ld_tx_data`. It resumes when `tx_empty` rises.
- `reset` pulsed during WAIT of byte 2 → all outputs 0 on the next cycle and no `send_done`. A new sample sent afterwards starts from its first byte.
- SAMPLE_BYTES=4, HEADER_BYTES=0, `sample_head`=1, data 0x00FF0000 → bytes 0x01, 0xFF, 0x01, 0x01 with no header bytes.

Source files
------------

// File: rtl/uart_pack_pkg.sv
// Shared types and constants for the UART frame packer and its host-side decoder model.
package uart_pack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [7:0] ZERO_SUB_DEFAULT = 8'h01;
    localparam logic [7:0] HEADER_BYTE      = 8'h00;

endpackage

// File: rtl/uart_byte_sel.sv
// Picks the outgoing byte for a given index: header zeros first, then sample bytes MSB-first
// with 0x00 replaced so the header pattern cannot appear inside data.
module uart_byte_sel
    import uart_pack_pkg::*;
#(
    parameter int unsigned SAMPLE_BYTES = 3,
    parameter int unsigned IW           = 3,
    parameter logic [7:0]  ZERO_SUB     = ZERO_SUB_DEFAULT
) (
    input  logic [SAMPLE_BYTES*8-1:0] sample_i,
    input  logic [IW-1:0]             byte_idx_i,
    input  logic [IW-1:0]             hdr_cnt_i,
    output logic [7:0]                byte_o_c
);

    logic [IW-1:0] data_pos;
    logic [7:0]    raw_byte;

    always_comb begin
        data_pos = byte_idx_i - hdr_cnt_i;
        raw_byte = 8'h00;
        // data_pos 0 selects the most significant byte
        for (int unsigned i = 0; i < SAMPLE_BYTES; i++) begin
            if (data_pos == IW'(SAMPLE_BYTES - 1 - i)) begin
                raw_byte = sample_i[8*i +: 8];
            end
        end
        if (byte_idx_i < hdr_cnt_i) begin
            byte_o_c = HEADER_BYTE;
        end else if (raw_byte == 8'h00) begin
            byte_o_c = ZERO_SUB;
        end else begin
            byte_o_c = raw_byte;
        end
    end

endmodule

// File: rtl/uart_frame_packer.sv
// Serialises one multi-byte sample per handshake into UART bytes, optionally prefixed by a
// zero-byte header, pacing each byte on the transmitter's tx_empty feedback.
module uart_frame_packer
    import uart_pack_pkg::*;
#(
    parameter int unsigned SAMPLE_BYTES = 3,
    parameter int unsigned HEADER_BYTES = 2,
    parameter logic [7:0]  ZERO_SUB     = ZERO_SUB_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic [SAMPLE_BYTES*8-1:0] sample_data,
    input  logic                      sample_head,
    output logic                      sample_ready,
    output logic                      ld_tx_data,
    output logic [7:0]                tx_data,
    output logic                      tx_enable,
    input  logic                      tx_empty,
    output logic                      send_done,
    output logic                      busy
);

    localparam int unsigned DW = SAMPLE_BYTES * 8;
    localparam int unsigned IW = $clog2(SAMPLE_BYTES + HEADER_BYTES + 1);

    if (SAMPLE_BYTES < 1 || SAMPLE_BYTES > 8) begin : g_bad_sample_bytes
        $error("uart_frame_packer: SAMPLE_BYTES=%0d outside 1..8", SAMPLE_BYTES);
    end
    if (HEADER_BYTES > 7) begin : g_bad_header_bytes
        $error("uart_frame_packer: HEADER_BYTES=%0d outside 0..7", HEADER_BYTES);
    end

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          head_q, head_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] total_q, total_d;
    logic          wait_first_q, wait_first_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          ld_q, ld_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] hdr_cnt_c;
    logic [7:0]    byte_c;

    assign hdr_cnt_c = head_q ? IW'(HEADER_BYTES) : '0;

    uart_byte_sel #(
        .SAMPLE_BYTES (SAMPLE_BYTES),
        .IW           (IW),
        .ZERO_SUB     (ZERO_SUB)
    ) u_byte_sel (
        .sample_i   (data_q),
        .byte_idx_i (idx_q),
        .hdr_cnt_i  (hdr_cnt_c),
        .byte_o_c   (byte_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        head_d       = head_q;
        idx_d        = idx_q;
        total_d      = total_q;
        wait_first_d = wait_first_q;
        tx_data_d    = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_valid && sample_ready) begin
                    data_d  = sample_data;
                    head_d  = sample_head;
                    idx_d   = '0;
                    total_d = IW'(SAMPLE_BYTES) + (sample_head ? IW'(HEADER_BYTES) : '0);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d = byte_c;
                state_d   = ST_LD;
            end
            ST_LD: begin
                wait_first_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // tx_empty lags the load by a cycle, so the first WAIT cycle is not trusted
                wait_first_d = 1'b0;
                if (!wait_first_q && tx_empty) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == total_q - IW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE || state_d == ST_DONE) begin
            tx_data_d = 8'h00;
        end
        ld_d   = (state_d == ST_LD);
        done_d = (state_d == ST_DONE);
        en_d   = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            head_q       <= 1'b0;
            idx_q        <= '0;
            total_q      <= '0;
            wait_first_q <= 1'b0;
            tx_data_q    <= 8'h00;
            ld_q         <= 1'b0;
            en_q         <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            head_q       <= head_d;
            idx_q        <= idx_d;
            total_q      <= total_d;
            wait_first_q <= wait_first_d;
            tx_data_q    <= tx_data_d;
            ld_q         <= ld_d;
            en_q         <= en_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign sample_ready = (state_q == ST_IDLE) && !reset;
    assign ld_tx_data   = ld_q;
    assign tx_data      = tx_data_q;
    assign tx_enable    = en_q;
    assign send_done    = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer with a tx_empty-driven UART model per instance.
module tb_uart_frame_packer;

    logic        clock;
    logic        reset;

    logic        sample_valid;
    logic [23:0] sample_data;
    logic        sample_head;
    logic        sample_ready;
    logic        ld_tx_data;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_empty = 1'b1;
    logic        send_done;
    logic        busy;

    logic        b_valid;
    logic [31:0] b_data;
    logic        b_head;
    logic        b_ready;
    logic        b_ld;
    logic [7:0]  b_txd;
    logic        b_en;
    logic        b_empty = 1'b1;
    logic        b_done;
    logic        b_busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int done_a = 0;
    int done_b = 0;
    int ready_viol = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    int byte_cyc = 3;
    bit stall = 1'b0;

    uart_frame_packer dut_a (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_head  (sample_head),
        .sample_ready (sample_ready),
        .ld_tx_data   (ld_tx_data),
        .tx_data      (tx_data),
        .tx_enable    (tx_enable),
        .tx_empty     (tx_empty),
        .send_done    (send_done),
        .busy         (busy)
    );

    uart_frame_packer #(
        .SAMPLE_BYTES (4),
        .HEADER_BYTES (0)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (b_valid),
        .sample_data  (b_data),
        .sample_head  (b_head),
        .sample_ready (b_ready),
        .ld_tx_data   (b_ld),
        .tx_data      (b_txd),
        .tx_enable    (b_en),
        .tx_empty     (b_empty),
        .send_done    (b_done),
        .busy         (b_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Byte capture plus UART models: tx_empty drops on load and rises byte_cyc cycles later
    always @(negedge clock) begin
        if (ld_tx_data) q_a.push_back(tx_data);
        if (send_done) done_a++;
        if (busy && sample_ready) ready_viol++;
        if (ld_tx_data) cnt_a = byte_cyc;
        else if (cnt_a > 0) cnt_a--;
        tx_empty = (cnt_a == 0) && !stall;

        if (b_ld) q_b.push_back(b_txd);
        if (b_done) done_b++;
        if (b_ld) cnt_b = byte_cyc;
        else if (cnt_b > 0) cnt_b--;
        b_empty = (cnt_b == 0);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp[i]));
        end
    endtask

    // Present a sample and return one cycle after it was accepted (DUT in LOAD)
    task automatic offer_a(input logic [23:0] d, input logic h, input bit keep_valid);
        int n;
        sample_data  = d;
        sample_head  = h;
        sample_valid = 1'b1;
        n = 0;
        while (!sample_ready && n < 2000) begin
            tick();
            n++;
        end
        check("accept_wait", 64'(sample_ready), 64'(1));
        tick();
        if (!keep_valid) sample_valid = 1'b0;
    endtask

    task automatic wait_done_a(input int target);
        int n;
        n = 0;
        while (done_a < target && n < 3000) begin
            tick();
            n++;
        end
        check("done_wait", 64'(done_a), 64'(target));
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int n;

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        sample_head  = 1'b0;
        b_valid      = 1'b0;
        b_data       = '0;
        b_head       = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ready", 64'(sample_ready), 64'(0));
        check("rst_ld", 64'(ld_tx_data), 64'(0));
        check("rst_txdata", 64'(tx_data), 64'(0));
        check("rst_en", 64'(tx_enable), 64'(0));
        check("rst_done", 64'(send_done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(0));
        reset = 1'b0;
        tick();
        check("idle_ready", 64'(sample_ready), 64'(1));

        // No header, embedded zero byte substituted
        q_a.delete();
        offer_a(24'h120034, 1'b0, 1'b0);
        check("load_busy", 64'(busy), 64'(1));
        check("load_en", 64'(tx_enable), 64'(1));
        check("load_ready", 64'(sample_ready), 64'(0));
        check("load_ld", 64'(ld_tx_data), 64'(0));
        check("load_txdata", 64'(tx_data), 64'(0));
        tick();
        check("ld_strobe", 64'(ld_tx_data), 64'(1));
        check("ld_txdata", 64'(tx_data), 64'(8'h12));
        tick();
        check("wait_ld_low", 64'(ld_tx_data), 64'(0));
        check("wait_txdata", 64'(tx_data), 64'(8'h12));
        wait_done_a(1);
        check("done_pulse", 64'(send_done), 64'(1));
        check("done_ready", 64'(sample_ready), 64'(0));
        check("done_txdata", 64'(tx_data), 64'(0));
        tick();
        check("after_done_pulse", 64'(send_done), 64'(0));
        check("after_done_ready", 64'(sample_ready), 64'(1));
        check("after_done_busy", 64'(busy), 64'(0));
        check("after_done_en", 64'(tx_enable), 64'(0));
        exp_q = '{8'h12, 8'h01, 8'h34};
        check_bytes("nohead", q_a, exp_q);
        repeat (5) tick();
        check("nohead_done_cnt", 64'(done_a), 64'(1));

        // Header sample
        q_a.delete();
        offer_a(24'hAABBCC, 1'b1, 1'b0);
        wait_done_a(2);
        exp_q = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        check_bytes("head", q_a, exp_q);

        // Back-to-back samples with sample_valid held high and slow UART bytes
        q_a.delete();
        byte_cyc = 10;
        offer_a(24'h010203, 1'b0, 1'b1);
        offer_a(24'h00FF00, 1'b0, 1'b1);
        offer_a(24'h445566, 1'b1, 1'b0);
        wait_done_a(5);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h44, 8'h55, 8'h66};
        check_bytes("b2b", q_a, exp_q);
        check("b2b_ready_during_frame", 64'(ready_viol), 64'(0));
        byte_cyc = 3;
        repeat (3) tick();

        // tx_empty stuck low holds the block in WAIT
        q_a.delete();
        stall = 1'b1;
        offer_a(24'h778899, 1'b0, 1'b0);
        repeat (51) tick();
        check("stall_loads", 64'(q_a.size()), 64'(1));
        check("stall_txdata", 64'(tx_data), 64'(8'h77));
        check("stall_ld", 64'(ld_tx_data), 64'(0));
        check("stall_busy", 64'(busy), 64'(1));
        stall = 1'b0;
        wait_done_a(6);
        exp_q = '{8'h77, 8'h88, 8'h99};
        check_bytes("stall", q_a, exp_q);

        // Reset during WAIT of the second byte aborts the frame
        q_a.delete();
        offer_a(24'hABCDEF, 1'b0, 1'b0);
        n = 0;
        while (q_a.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        check("abort_reach_byte2", 64'(q_a.size()), 64'(2));
        repeat (2) tick();
        reset = 1'b1;
        check("abort_ready_in_reset", 64'(sample_ready), 64'(0));
        tick();
        check("abort_ld", 64'(ld_tx_data), 64'(0));
        check("abort_txdata", 64'(tx_data), 64'(0));
        check("abort_en", 64'(tx_enable), 64'(0));
        check("abort_done", 64'(send_done), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_ready", 64'(sample_ready), 64'(0));
        reset = 1'b0;
        repeat (20) tick();
        check("abort_no_done", 64'(done_a), 64'(6));
        check("abort_no_more_loads", 64'(q_a.size()), 64'(2));
        q_a.delete();
        offer_a(24'h0A0B0C, 1'b0, 1'b0);
        wait_done_a(7);
        exp_q = '{8'h0A, 8'h0B, 8'h0C};
        check_bytes("post_abort", q_a, exp_q);

        // Four-byte sample, no header configured: sample_head ignored, zeros substituted
        q_b.delete();
        b_data  = 32'h00FF0000;
        b_head  = 1'b1;
        b_valid = 1'b1;
        n = 0;
        while (!b_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        b_valid = 1'b0;
        n = 0;
        while (done_b < 1 && n < 500) begin
            tick();
            n++;
        end
        check("b_done_wait", 64'(done_b), 64'(1));
        exp_q = '{8'h01, 8'hFF, 8'h01, 8'h01};
        check_bytes("b_nohdr", q_b, exp_q);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
